johnson_decoder: RTL and testbench
==================================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 3: number of consecutive in-sequence legal codes needed to enter LOCKED (range 1..7).
REQ-002 Parameter ERR_LIMIT, default 2: number of consecutive bad samples in LOCKED that force return to HUNT (range 1..7).
REQ-003 Parameter CNT_W, default 8: width of err_cnt.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 q_in  input  4  Johnson-coded sample from a 4-bit Johnson counter.
REQ-007 valid_in  input  1  q_in is sampled only when high.
REQ-008 bin_out  output  3  binary index of the last legal code received.
REQ-009 bin_valid  output  1  one-cycle pulse: bin_out updated from a legal sample.
REQ-010 illegal  output  1  one-cycle pulse: sampled code not in the Johnson set.
REQ-011 seq_err  output  1  one-cycle pulse: sequence violation while LOCKED.
REQ-012 locked  output  1  high while the state machine is in LOCKED.
REQ-013 err_cnt  output  CNT_W  saturating count of seq_err pulses.

Function
REQ-014 Legal code map SHALL be 0->0, 1->1, 3->2, 7->3, F->4, E->5, C->6, 8->7; codes 2,4,5,6,9,A,B,D SHALL be illegal.
REQ-015 All outputs SHALL be registered; the response to a sample SHALL appear exactly one cycle after the clock edge where valid_in=1.
REQ-016 valid_in=0 SHALL leave state, counters, bin_out and err_cnt unchanged; bin_valid, illegal and seq_err SHALL be 0 the following cycle.
REQ-017 Expected next index SHALL be (last_idx+1) mod 8; idx 7 -> 0 is a legal in-sequence step (wrap-around).
REQ-018 A legal sample SHALL load bin_out and last_idx with its index and pulse bin_valid, in any state.
REQ-019 An illegal sample SHALL pulse illegal and leave bin_out unchanged, in any state.
REQ-020 States SHALL be HUNT, CHECK and LOCKED; good_cnt and bad_cnt are internal 3-bit counters.
REQ-021 HUNT: legal sample -> CHECK with good_cnt=1 (or directly to LOCKED if LOCK_COUNT=1); illegal -> stay.
REQ-022 CHECK: in-sequence legal sample -> good_cnt+1, and LOCKED when good_cnt+1 = LOCK_COUNT; out-of-sequence legal sample -> stay with good_cnt=1; illegal -> HUNT, good_cnt=0.
REQ-023 CHECK and HUNT SHALL never pulse seq_err or change err_cnt.
REQ-024 LOCKED: in-sequence legal sample -> stay, bad_cnt=0.
REQ-025 LOCKED: out-of-sequence legal sample (including a repeated code) -> seq_err pulse, err_cnt+1, bad_cnt+1, last_idx resynchronised to received index.
REQ-026 LOCKED: illegal sample -> seq_err and illegal pulses, err_cnt+1, bad_cnt+1, last_idx advanced by 1 mod 8 (free-wheel), bin_out unchanged.
REQ-027 LOCKED: when bad_cnt+1 = ERR_LIMIT -> HUNT, bad_cnt=0, good_cnt=0; locked falls the following cycle.
REQ-028 err_cnt SHALL saturate at 2^CNT_W-1 and SHALL be cleared only by reset.

Reset
REQ-029 reset=1 at a clock edge SHALL force HUNT, good_cnt=0, bad_cnt=0, last_idx=0, bin_out=0, bin_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0 the following cycle.
REQ-030 reset SHALL take priority over valid_in; a sample present during reset SHALL be discarded.
REQ-031 Reset asserted mid-operation (any state) SHALL behave identically to power-on reset.

Verification (defaults LOCK_COUNT=3, ERR_LIMIT=2, CNT_W=8)
REQ-032 Reset 2 cycles, then valid codes 0,1,3 -> bin_out 0,1,2 with bin_valid pulses; locked=1 one cycle after code 3 is sampled.
REQ-033 Locked, continue 7,F,E,C,8,0 -> bin_out 3,4,5,6,7,0, seq_err never asserted, err_cnt=0 (wrap-around).
REQ-034 Locked at idx 3 (code 7), send E then C -> seq_err pulse on E, err_cnt=1, locked stays 1, no error on C (resync).
REQ-035 Locked, send illegal 5 then A -> illegal and seq_err pulse twice, err_cnt increases by 2, locked=0 after the second; bin_out unchanged.
REQ-036 Locked, valid_in=0 for 3 cycles, then the next in-sequence code -> no pulses during the gap, no error after it.
REQ-037 valid_in=1 with q_in=1 while reset=1 in LOCKED with err_cnt=5 -> next cycle all outputs 0, state HUNT; CNT_W=2 run of 5 errors -> err_cnt holds at 3.

Source files
------------

// File: rtl/johnson_decoder.sv
// Decodes a 4-bit Johnson code into a binary index and tracks sequence lock (HUNT/CHECK/LOCKED).
// Latency: 1 cycle, registered outputs. Backpressure: none; samples are taken whenever valid_in is high.
module johnson_decoder #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       q_in,
    input  logic             valid_in,
    output logic [2:0]       bin_out,
    output logic             bin_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    localparam logic [2:0]       LOCK_C  = 3'(LOCK_COUNT);
    localparam logic [2:0]       ERR_C   = 3'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

    state_t     state;
    logic [2:0] good_cnt;
    logic [2:0] bad_cnt;
    logic [2:0] last_idx;
    logic [2:0] next_idx;
    logic [2:0] code_idx;
    logic       code_legal;
    logic       in_seq;

    always_comb begin
        code_legal = 1'b1;
        code_idx   = 3'd0;
        case (q_in)
            4'h0: code_idx = 3'd0;
            4'h1: code_idx = 3'd1;
            4'h3: code_idx = 3'd2;
            4'h7: code_idx = 3'd3;
            4'hF: code_idx = 3'd4;
            4'hE: code_idx = 3'd5;
            4'hC: code_idx = 3'd6;
            4'h8: code_idx = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // 3-bit arithmetic gives the 7 -> 0 wrap for free
    assign next_idx = last_idx + 3'd1;
    assign in_seq   = (code_idx == next_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            good_cnt  <= 3'd0;
            bad_cnt   <= 3'd0;
            last_idx  <= 3'd0;
            bin_out   <= 3'd0;
            bin_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            bin_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            if (valid_in) begin
                if (code_legal) begin
                    bin_out   <= code_idx;
                    last_idx  <= code_idx;
                    bin_valid <= 1'b1;
                end else begin
                    illegal <= 1'b1;
                end

                case (state)
                    HUNT: begin
                        if (code_legal) begin
                            good_cnt <= 3'd1;
                            if (LOCK_C == 3'd1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (!code_legal) begin
                            state    <= HUNT;
                            good_cnt <= 3'd0;
                        end else if (in_seq) begin
                            good_cnt <= good_cnt + 3'd1;
                            if (good_cnt + 3'd1 == LOCK_C) begin
                                state   <= LOCKED;
                                bad_cnt <= 3'd0;
                                locked  <= 1'b1;
                            end
                        end else begin
                            good_cnt <= 3'd1;
                        end
                    end
                    LOCKED: begin
                        if (code_legal && in_seq) begin
                            bad_cnt <= 3'd0;
                        end else begin
                            seq_err <= 1'b1;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ERR_ONE;
                            // illegal codes free-wheel the expected index; legal ones resync above
                            if (!code_legal)
                                last_idx <= next_idx;
                            if (bad_cnt + 3'd1 == ERR_C) begin
                                state    <= HUNT;
                                bad_cnt  <= 3'd0;
                                good_cnt <= 3'd0;
                                locked   <= 1'b0;
                            end else begin
                                bad_cnt <= bad_cnt + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder; a second CNT_W=2 instance shares the stimulus to check saturation.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] q_in;
    logic       valid_in;

    logic [2:0] bin_out,  bin_out2;
    logic       bin_valid, bin_valid2;
    logic       illegal,  illegal2;
    logic       seq_err,  seq_err2;
    logic       locked,   locked2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    johnson_decoder dut (
        .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in),
        .bin_out(bin_out), .bin_valid(bin_valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    johnson_decoder #(.LOCK_COUNT(3), .ERR_LIMIT(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .q_in(q_in), .valid_in(valid_in),
        .bin_out(bin_out2), .bin_valid(bin_valid2), .illegal(illegal2),
        .seq_err(seq_err2), .locked(locked2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then check the registered response #1 after the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] q,
                        input logic [2:0] e_bin, input logic e_bv, input logic e_ill,
                        input logic e_se, input logic e_lk, input logic [7:0] e_err,
                        input logic [1:0] e_err2);
        reset    = r;
        valid_in = v;
        q_in     = q;
        @(posedge clk);
        #1;
        chk({tag, ".bin_out"},   8'(bin_out),   8'(e_bin));
        chk({tag, ".bin_valid"}, 8'(bin_valid), 8'(e_bv));
        chk({tag, ".illegal"},   8'(illegal),   8'(e_ill));
        chk({tag, ".seq_err"},   8'(seq_err),   8'(e_se));
        chk({tag, ".locked"},    8'(locked),    8'(e_lk));
        chk({tag, ".err_cnt"},   err_cnt,       e_err);
        chk({tag, ".err_cnt2"},  8'(err_cnt2),  8'(e_err2));
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; q_in = 4'h0;
        #1;
        //    tag      rst vld code  bin bv ill se lk err e2
        step("rst0",   1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        step("rst1",   1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0);

        // acquire lock on 0,1,3
        step("acq0",   0, 1, 4'h0, 0, 1, 0, 0, 0, 0, 0);
        step("acq1",   0, 1, 4'h1, 1, 1, 0, 0, 0, 0, 0);
        step("acq3",   0, 1, 4'h3, 2, 1, 0, 0, 1, 0, 0);

        // full cycle with wrap-around
        step("run7",   0, 1, 4'h7, 3, 1, 0, 0, 1, 0, 0);
        step("runF",   0, 1, 4'hF, 4, 1, 0, 0, 1, 0, 0);
        step("runE",   0, 1, 4'hE, 5, 1, 0, 0, 1, 0, 0);
        step("runC",   0, 1, 4'hC, 6, 1, 0, 0, 1, 0, 0);
        step("run8",   0, 1, 4'h8, 7, 1, 0, 0, 1, 0, 0);
        step("wrap0",  0, 1, 4'h0, 0, 1, 0, 0, 1, 0, 0);

        // skip from idx 3 to 5, then resync continues cleanly
        step("pre1",   0, 1, 4'h1, 1, 1, 0, 0, 1, 0, 0);
        step("pre3",   0, 1, 4'h3, 2, 1, 0, 0, 1, 0, 0);
        step("pre7",   0, 1, 4'h7, 3, 1, 0, 0, 1, 0, 0);
        step("skipE",  0, 1, 4'hE, 5, 1, 0, 1, 1, 1, 1);
        step("resyC",  0, 1, 4'hC, 6, 1, 0, 0, 1, 1, 1);

        // two illegal codes drop lock, bin_out held
        step("ill5",   0, 1, 4'h5, 6, 0, 1, 1, 1, 2, 2);
        step("illA",   0, 1, 4'hA, 6, 0, 1, 1, 0, 3, 3);

        // relock, then an idle gap
        step("rl0",    0, 1, 4'h0, 0, 1, 0, 0, 0, 3, 3);
        step("rl1",    0, 1, 4'h1, 1, 1, 0, 0, 0, 3, 3);
        step("rl3",    0, 1, 4'h3, 2, 1, 0, 0, 1, 3, 3);
        step("gap0",   0, 0, 4'h5, 2, 0, 0, 0, 1, 3, 3);
        step("gap1",   0, 0, 4'hA, 2, 0, 0, 0, 1, 3, 3);
        step("gap2",   0, 0, 4'h2, 2, 0, 0, 0, 1, 3, 3);
        step("aft7",   0, 1, 4'h7, 3, 1, 0, 0, 1, 3, 3);

        // repeated/backward codes: errors while lock holds; narrow counter saturates
        step("back3",  0, 1, 4'h3, 2, 1, 0, 1, 1, 4, 3);
        step("fwd7",   0, 1, 4'h7, 3, 1, 0, 0, 1, 4, 3);
        step("rep7",   0, 1, 4'h7, 3, 1, 0, 1, 1, 5, 3);

        // reset wins over a valid sample while locked
        step("mrst",   1, 1, 4'h1, 0, 0, 0, 0, 0, 0, 0);

        // back in HUNT: illegal stays, illegal in CHECK returns to HUNT
        step("h_ill",  0, 1, 4'h2, 0, 0, 1, 0, 0, 0, 0);
        step("h_1",    0, 1, 4'h1, 1, 1, 0, 0, 0, 0, 0);
        step("c_ill",  0, 1, 4'h9, 1, 0, 1, 0, 0, 0, 0);
        step("h_3",    0, 1, 4'h3, 2, 1, 0, 0, 0, 0, 0);
        step("c_7",    0, 1, 4'h7, 3, 1, 0, 0, 0, 0, 0);
        step("c_F",    0, 1, 4'hF, 4, 1, 0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
